cnt_seq_ctrl: RTL and testbench

- Sequencing controller for a modulo-N up-counter datapath.
- Holds a programmable terminal value and repeat count, loaded through a valid/ready config handshake.
- Runs the counter under start/pause/stop commands and reports wrap, busy and done status to the surrounding lab logic.
- Sits between the command/config source (switches or testbench) and any logic consuming the count.

---
 rtl/cnt_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller for a modulo-(term+1) up-counter with a config handshake and run/hold/done control.
// Optional: define CNT_SEQ_CTRL_WRAPCNT_EN to add the saturating wrap_total output.
module cnt_seq_ctrl #(
  parameter int WIDTH    = 5,
  parameter int DEF_TERM = 17,
  parameter int REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_term,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
`ifdef CNT_SEQ_CTRL_WRAPCNT_EN
  ,
  output logic [15:0]      wrap_total
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] term_reg;
  logic [REP_W-1:0] reps_reg;
  logic [REP_W-1:0] rep_cnt_reg;
  logic             wrap_reg;
  logic             done_reg;

  logic             cfg_accept;
  logic             at_term;
  logic [REP_W-1:0] rep_next;
  logic             last_period;
  logic             wrap_event;

  assign cfg_ready   = (state_reg == IDLE) || (state_reg == DONE);
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign at_term     = (cnt_reg >= term_reg);
  assign rep_next    = rep_cnt_reg + REP_ONE;
  assign last_period = (reps_reg != '0) && (rep_next == reps_reg);
  // A wrap happens only on an advancing RUN edge (no stop/pause) with cnt at term.
  assign wrap_event  = (state_reg == RUN) && !stop && !pause && at_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      term_reg    <= WIDTH'(DEF_TERM);
      reps_reg    <= '0;
      rep_cnt_reg <= '0;
      wrap_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      done_reg <= 1'b0;
      if (cfg_accept) begin
        term_reg    <= cfg_term;
        reps_reg    <= cfg_reps;
        rep_cnt_reg <= '0;
      end
      case (state_reg)
        IDLE, DONE: begin
          cnt_reg <= '0;
          if (stop) begin
            state_reg <= IDLE;
          end else if (start) begin
            state_reg   <= RUN;
            rep_cnt_reg <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (pause) begin
            state_reg <= HOLD;
          end else if (at_term) begin
            cnt_reg     <= '0;
            wrap_reg    <= 1'b1;
            rep_cnt_reg <= rep_next;
            if (last_period) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        HOLD: begin
          if (stop) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (!pause && start) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CNT_SEQ_CTRL_WRAPCNT_EN
  logic [15:0] wrap_total_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_total_reg <= '0;
    end else if (cfg_accept) begin
      wrap_total_reg <= '0;
    end else if (wrap_event && (wrap_total_reg != 16'hFFFF)) begin
      wrap_total_reg <= wrap_total_reg + 16'd1;
    end
  end

  assign wrap_total = wrap_total_reg;
`endif

  assign cnt   = cnt_reg;
  assign wrap  = wrap_reg;
  assign done  = done_reg;
  assign busy  = (state_reg == RUN) || (state_reg == HOLD);
  assign state = state_reg;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl: a run-position model predicts outputs per edge, a monitor compares them.
// Define CNT_SEQ_CTRL_WRAPCNT_EN to also check wrap_total.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_term;
  logic [3:0] cfg_reps;
  logic       start;
  logic       pause;
  logic       stop;
  logic [4:0] cnt;
  logic       wrap;
  logic       done;
  logic       busy;
  logic [1:0] state;
`ifdef CNT_SEQ_CTRL_WRAPCNT_EN
  logic [15:0] wrap_total;
`endif

  cnt_seq_ctrl #(.WIDTH(5), .DEF_TERM(17), .REP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_term(cfg_term),
    .cfg_reps(cfg_reps),
    .start(start),
    .pause(pause),
    .stop(stop),
    .cnt(cnt),
    .wrap(wrap),
    .done(done),
    .busy(busy),
    .state(state)
`ifdef CNT_SEQ_CTRL_WRAPCNT_EN
    ,
    .wrap_total(wrap_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  cnt;
    logic        wrap;
    logic        done;
    logic        busy;
    logic        ready;
    logic [1:0]  state;
    logic [15:0] wt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: mode 0=IDLE 1=RUN 2=HOLD 3=DONE; m_p = counting edges since the run started.
  int m_mode, m_p, m_term, m_reps, m_wt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_term = 17; m_reps = 0; m_wt = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   per;
    e.wrap = 1'b0;
    e.done = 1'b0;
    if ((m_mode == 0 || m_mode == 3) && cfg_valid) begin
      m_term = int'(cfg_term);
      m_reps = int'(cfg_reps);
      m_wt   = 0;
      $display("cfg accepted: term=%0d reps=%0d start=%0b", m_term, m_reps, start);
    end
    per = m_term + 1;
    case (m_mode)
      0, 3: begin
        if (stop) m_mode = 0;
        else if (start) begin m_mode = 1; m_p = 0; end
      end
      1: begin
        if (stop) begin
          m_mode = 0; m_p = 0;
        end else if (pause) begin
          m_mode = 2;
        end else begin
          m_p++;
          if (m_p % per == 0) begin
            e.wrap = 1'b1;
            if (m_wt < 65535) m_wt++;
            if (m_reps != 0 && m_p == per * m_reps) begin
              m_mode = 3; e.done = 1'b1; m_p = 0;
              $display("run done: term=%0d reps=%0d", m_term, m_reps);
            end
          end
        end
      end
      default: begin
        if (stop) begin m_mode = 0; m_p = 0; end
        else if (!pause && start) m_mode = 1;
      end
    endcase
    e.cnt   = (m_mode == 1 || m_mode == 2) ? 5'(m_p % per) : 5'd0;
    e.busy  = (m_mode == 1 || m_mode == 2);
    e.ready = (m_mode == 0 || m_mode == 3);
    e.state = 2'(m_mode);
    e.wt    = 16'(m_wt);
    sb.push_back(e);
  endtask

  task automatic step(input logic cv, input logic [4:0] ct, input logic [3:0] cr,
                      input logic st, input logic pa, input logic sp);
    @(negedge clk);
    cfg_valid = cv; cfg_term = ct; cfg_reps = cr;
    start = st; pause = pa; stop = sp;
    model_step();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("cnt", 32'(cnt), 32'(mon_e.cnt));
      chk("wrap", 32'(wrap), 32'(mon_e.wrap));
      chk("done", 32'(done), 32'(mon_e.done));
      chk("busy", 32'(busy), 32'(mon_e.busy));
      chk("cfg_ready", 32'(cfg_ready), 32'(mon_e.ready));
      chk("state", 32'(state), 32'(mon_e.state));
`ifdef CNT_SEQ_CTRL_WRAPCNT_EN
      chk("wrap_total", 32'(wrap_total), 32'(mon_e.wt));
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic cv, st, pa, sp;
    logic [4:0] ct;
    logic [3:0] cr;
    rst = 1'b1; cfg_valid = 1'b0; cfg_term = '0; cfg_reps = '0;
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_pulses", 32'({wrap, done}), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    // Default run: wraps at 17, no done.
    $display("phase: default run");
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(40);
    step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Config term=3 reps=2 together with start.
    $display("phase: term3 reps2");
    step(1'b1, 5'd3, 4'd2, 1'b1, 1'b0, 1'b0);
    idle_steps(10);

    // Pause at cnt=5, hold 4 cycles, resume.
    $display("phase: pause/resume");
    step(1'b1, 5'd9, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(5);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(3);
    step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // stop+start+pause together at cnt=7.
    $display("phase: command priority");
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(7);
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    idle_steps(2);

    // Config ignored while running, accepted after stop.
    $display("phase: config while busy");
    step(1'b1, 5'd17, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step(1'b1, 5'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(8);
    step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-run at cnt=12, then confirm term is back to 17.
    $display("phase: async reset");
    step(1'b1, 5'd20, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(12);
    @(posedge clk);
    #3;
    chk("pre_rst_cnt", 32'(cnt), 32'd12);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_pulses", 32'({wrap, done}), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(20);
    step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // term=0: wrap every cycle; config afterwards clears the wrap tally.
    $display("phase: term0");
    step(1'b1, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(20);
    step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd4, 4'd1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    $display("phase: random");
    for (int i = 0; i < 2000; i++) begin
      cv = ($urandom_range(0, 7) == 0);
      ct = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      cr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      st = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 39) == 0);
      if (pa) st = 1'b0;
      step(cv, ct, cr, st, pa, sp);
    end
    idle_steps(2);
    @(posedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
